board_rst_led_ctrl: RTL and testbench



---
 rtl/board_rst_led_ctrl_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/board_rst_led_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_board_rst_led_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/board_rst_led_ctrl_pkg.sv
// Shared types for the board reset/LED controller: LED mode encoding and
// reset sequencer states.
package board_ctrl_pkg;

    typedef enum logic [1:0] {
        LED_OFF       = 2'b00,
        LED_ON        = 2'b01,
        LED_BLINK     = 2'b10,
        LED_HEARTBEAT = 2'b11
    } led_mode_e;

    typedef enum logic [1:0] {
        ST_STRETCH = 2'b00,
        ST_RELEASE = 2'b01,
        ST_RUN     = 2'b10
    } rst_state_e;

    // Heartbeat is lit for the first eighth of each blink period.
    function automatic logic heartbeat_on(input logic [2:0] top_bits);
        return (top_bits == 3'b000);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: 2-flop synchroniser, stable-count debounce
// and a one-cycle pulse on each debounced rising edge.
module btn_debounce
    import board_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 32000
) (
    input  logic clk_soc,
    input  logic rstn_soc,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk_soc or negedge rstn_soc) begin
        if (!rstn_soc) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Any return to the current level restarts the count, so short glitches die here.
    always_ff @(posedge clk_soc or negedge rstn_soc) begin
        if (!rstn_soc) begin
            stable_cnt <= '0;
            btn_db     <= 1'b0;
            btn_rise   <= 1'b0;
        end else begin
            btn_rise <= 1'b0;
            if (sync_q2 == btn_db) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                stable_cnt <= '0;
                btn_db     <= sync_q2;
                btn_rise   <= sync_q2;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/board_rst_led_ctrl.sv
// Board-level control: debounced buttons, ordered release of downstream
// active-low resets, and per-LED status modes driven from a blink counter.
module board_rst_led_ctrl
    import board_ctrl_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYC    = 32000,
    parameter int RST_BTN         = 1,
    parameter int NUM_RST         = 2,
    parameter int RST_STRETCH_CYC = 64,
    parameter int RST_GAP_CYC     = 16,
    parameter int NUM_LED         = 4,
    parameter int BLINK_W         = 24
) (
    input  logic                 clk_soc,
    input  logic                 rstn_soc,
    input  logic [NUM_BTN-1:0]   btn_i,
    input  logic                 rst_req_i,
    input  logic [2*NUM_LED-1:0] led_mode_i,
    output logic [NUM_BTN-1:0]   btn_o,
    output logic [NUM_BTN-1:0]   btn_rise_o,
    output logic [NUM_RST-1:0]   rstn_o,
    output logic                 rst_busy_o,
    output logic [NUM_LED-1:0]   led_o
);

    localparam int SCNT_W = $clog2(RST_STRETCH_CYC + 1);
    localparam int GCNT_W = $clog2(RST_GAP_CYC + 1);
    localparam int IDX_W  = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_btn_debounce (
                .clk_soc (clk_soc),
                .rstn_soc(rstn_soc),
                .btn_raw (btn_i[gi]),
                .btn_db  (btn_o[gi]),
                .btn_rise(btn_rise_o[gi])
            );
        end
    endgenerate

    rst_state_e         state;
    rst_state_e         state_nxt;
    logic [SCNT_W-1:0]  stretch_cnt;
    logic [SCNT_W-1:0]  stretch_cnt_nxt;
    logic [GCNT_W-1:0]  gap_cnt;
    logic [GCNT_W-1:0]  gap_cnt_nxt;
    logic [IDX_W-1:0]   rel_idx;
    logic [IDX_W-1:0]   rel_idx_nxt;
    logic [NUM_RST-1:0] rstn_nxt;
    logic               req;
    logic               stretch_hold;
    logic               stretch_done;
    logic               gap_done;
    logic               last_idx;

    assign req          = rst_req_i | btn_rise_o[RST_BTN];
    assign stretch_hold = req | btn_o[RST_BTN];
    assign stretch_done = (stretch_cnt == SCNT_W'(RST_STRETCH_CYC - 1));
    assign gap_done     = (gap_cnt == GCNT_W'(RST_GAP_CYC - 1));
    assign last_idx     = (rel_idx == IDX_W'(NUM_RST - 1));

    always_ff @(posedge clk_soc or negedge rstn_soc) begin
        if (!rstn_soc) begin
            state       <= ST_STRETCH;
            stretch_cnt <= '0;
            gap_cnt     <= '0;
            rel_idx     <= '0;
            rstn_o      <= '0;
            rst_busy_o  <= 1'b1;
        end else begin
            state       <= state_nxt;
            stretch_cnt <= stretch_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            rel_idx     <= rel_idx_nxt;
            rstn_o      <= rstn_nxt;
            rst_busy_o  <= ~&rstn_nxt;
        end
    end

    // A request always takes priority over a release edge in the same cycle.
    always_comb begin
        state_nxt       = state;
        stretch_cnt_nxt = stretch_cnt;
        gap_cnt_nxt     = gap_cnt;
        rel_idx_nxt     = rel_idx;
        case (state)
            ST_STRETCH: begin
                if (stretch_hold) begin
                    stretch_cnt_nxt = '0;
                end else if (stretch_done) begin
                    stretch_cnt_nxt = '0;
                    gap_cnt_nxt     = '0;
                    rel_idx_nxt     = IDX_W'(1);
                    state_nxt       = (NUM_RST == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    stretch_cnt_nxt = stretch_cnt + SCNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (req) begin
                    stretch_cnt_nxt = '0;
                    state_nxt       = ST_STRETCH;
                end else if (gap_done) begin
                    gap_cnt_nxt = '0;
                    rel_idx_nxt = rel_idx + IDX_W'(1);
                    if (last_idx) begin
                        state_nxt = ST_RUN;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt + GCNT_W'(1);
                end
            end
            ST_RUN: begin
                if (req) begin
                    stretch_cnt_nxt = '0;
                    state_nxt       = ST_STRETCH;
                end
            end
            default: begin
                stretch_cnt_nxt = '0;
                state_nxt       = ST_STRETCH;
            end
        endcase
    end

    always_comb begin
        rstn_nxt = rstn_o;
        case (state)
            ST_STRETCH: begin
                rstn_nxt = '0;
                if (!stretch_hold && stretch_done) begin
                    rstn_nxt[0] = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (req) begin
                    rstn_nxt = '0;
                end else if (gap_done) begin
                    rstn_nxt[rel_idx] = 1'b1;
                end
            end
            ST_RUN: begin
                rstn_nxt = req ? '0 : '1;
            end
            default: begin
                rstn_nxt = '0;
            end
        endcase
    end

    logic [BLINK_W-1:0] blink_cnt;
    logic [NUM_LED-1:0] led_nxt;

    always_comb begin
        led_nxt = '0;
        for (int k = 0; k < NUM_LED; k++) begin
            case (led_mode_e'(led_mode_i[2*k +: 2]))
                LED_OFF:       led_nxt[k] = 1'b0;
                LED_ON:        led_nxt[k] = 1'b1;
                LED_BLINK:     led_nxt[k] = blink_cnt[BLINK_W-1];
                LED_HEARTBEAT: led_nxt[k] = heartbeat_on(blink_cnt[BLINK_W-1 -: 3]);
                default:       led_nxt[k] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_soc or negedge rstn_soc) begin
        if (!rstn_soc) begin
            blink_cnt <= '0;
            led_o     <= '0;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
            led_o     <= led_nxt;
        end
    end

endmodule

// File: tb/tb_board_rst_led_ctrl.sv
// Directed bench for board_rst_led_ctrl: reset sequencing, debounce, request
// handling and LED modes with small parameters.
module tb_board_rst_led_ctrl;

    logic       clk_soc;
    logic       rstn_soc;
    logic [3:0] btn_i;
    logic       rst_req_i;
    logic [7:0] led_mode_i;
    logic [3:0] btn_o;
    logic [3:0] btn_rise_o;
    logic [2:0] rstn_o;
    logic       rst_busy_o;
    logic [3:0] led_o;

    int errors = 0;
    int checks = 0;

    board_rst_led_ctrl #(
        .NUM_BTN        (4),
        .DEBOUNCE_CYC   (4),
        .RST_BTN        (1),
        .NUM_RST        (3),
        .RST_STRETCH_CYC(8),
        .RST_GAP_CYC    (3),
        .NUM_LED        (4),
        .BLINK_W        (6)
    ) dut (
        .clk_soc   (clk_soc),
        .rstn_soc  (rstn_soc),
        .btn_i     (btn_i),
        .rst_req_i (rst_req_i),
        .led_mode_i(led_mode_i),
        .btn_o     (btn_o),
        .btn_rise_o(btn_rise_o),
        .rstn_o    (rstn_o),
        .rst_busy_o(rst_busy_o),
        .led_o     (led_o)
    );

    initial begin
        clk_soc = 1'b0;
        forever #5 clk_soc = ~clk_soc;
    end

    typedef struct {
        logic       req;
        logic [2:0] rstn;
        logic       busy;
    } vec_t;

    vec_t vecs[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_soc);
        #1;
    endtask

    task automatic set_vecs(input int lo, input int hi, input logic req,
                            input logic [2:0] rstn, input logic busy);
        for (int i = lo; i <= hi; i++) begin
            vecs[i].req  = req;
            vecs[i].rstn = rstn;
            vecs[i].busy = busy;
        end
    endtask

    initial begin
        int   rises;
        int   fall_edge;
        logic bad;
        logic prev;
        logic [3:0] exp_led;
        int   c;

        rstn_soc   = 1'b0;
        btn_i      = '0;
        rst_req_i  = 1'b0;
        led_mode_i = '0;

        // Entry i describes the cycle ending at edge i+1 after reset release.
        set_vecs(0, 6, 1'b0, 3'b000, 1'b1);
        set_vecs(7, 9, 1'b0, 3'b001, 1'b1);
        set_vecs(10, 12, 1'b0, 3'b011, 1'b1);
        set_vecs(13, 14, 1'b0, 3'b111, 1'b0);
        set_vecs(15, 15, 1'b1, 3'b000, 1'b1);
        set_vecs(16, 22, 1'b0, 3'b000, 1'b1);
        set_vecs(23, 25, 1'b0, 3'b001, 1'b1);
        set_vecs(26, 28, 1'b0, 3'b011, 1'b1);
        set_vecs(29, 31, 1'b0, 3'b111, 1'b0);

        repeat (3) tick();
        chk("rst_btn_o", btn_o, 4'h0);
        chk("rst_btn_rise_o", btn_rise_o, 4'h0);
        chk("rst_rstn_o", rstn_o, 3'b000);
        chk("rst_busy_o", rst_busy_o, 1'b1);
        chk("rst_led_o", led_o, 4'h0);

        // Release sequence and a software request in RUN.
        rstn_soc = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rst_req_i = vecs[i].req;
            tick();
            chk($sformatf("tbl%0d_rstn", i), rstn_o, vecs[i].rstn);
            chk($sformatf("tbl%0d_busy", i), rst_busy_o, vecs[i].busy);
        end
        rst_req_i = 1'b0;
        chk("led_off_mode", led_o, 4'h0);

        // Debounce: a 3-cycle glitch is rejected.
        btn_i[0] = 1'b1;
        repeat (3) tick();
        btn_i[0] = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            tick();
            if (btn_o[0] || btn_rise_o[0]) bad = 1'b1;
        end
        chk("glitch_rejected", bad, 1'b0);

        // Debounce: a 6-cycle pulse gets through after 6 edges.
        rises = 0;
        btn_i[0] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            rises += btn_rise_o[0];
            if (e == 5) chk("pulse_btn_o_e5", btn_o[0], 1'b0);
            if (e == 6) begin
                chk("pulse_btn_o_e6", btn_o[0], 1'b1);
                chk("pulse_rise_e6", btn_rise_o[0], 1'b1);
            end
        end
        btn_i[0] = 1'b0;
        repeat (12) begin
            tick();
            rises += btn_rise_o[0];
        end
        chk("pulse_rise_count", rises, 1);
        chk("pulse_btn_o_fell", btn_o[0], 1'b0);
        chk("btn0_no_reset", rstn_o, 3'b111);

        // Holding the reset button keeps the stretch frozen until release.
        btn_i[1] = 1'b1;
        bad = 1'b0;
        fall_edge = -1;
        prev = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            if (e == 21) btn_i[1] = 1'b0;
            tick();
            if (prev && !btn_o[1] && fall_edge < 0) fall_edge = e;
            prev = btn_o[1];
            if (e == 6) begin
                chk("hold_btn_o_rise", btn_o[1], 1'b1);
                chk("hold_rstn_e6", rstn_o, 3'b111);
            end
            if (e == 7) chk("hold_rstn_e7", rstn_o, 3'b000);
            if (e >= 8 && e <= 33 && (rstn_o !== 3'b000 || rst_busy_o !== 1'b1)) bad = 1'b1;
            if (e == 34) chk("hold_rstn_e34", rstn_o, 3'b001);
            if (e == 37) chk("hold_rstn_e37", rstn_o, 3'b011);
            if (e == 40) begin
                chk("hold_rstn_e40", rstn_o, 3'b111);
                chk("hold_busy_e40", rst_busy_o, 1'b0);
            end
        end
        chk("hold_asserted_window", bad, 1'b0);
        chk("hold_fall_edge", fall_edge, 26);

        // Request colliding with the release of channel 1.
        rst_req_i = 1'b1;
        tick();
        rst_req_i = 1'b0;
        chk("coll_req_rstn", rstn_o, 3'b000);
        repeat (8) tick();
        chk("coll_rstn_a8", rstn_o, 3'b001);
        repeat (2) tick();
        chk("coll_rstn_a10", rstn_o, 3'b001);
        rst_req_i = 1'b1;
        tick();
        rst_req_i = 1'b0;
        chk("coll_rstn_a11", rstn_o, 3'b000);
        chk("coll_busy_a11", rst_busy_o, 1'b1);
        repeat (7) tick();
        chk("coll_rstn_a18", rstn_o, 3'b000);
        tick();
        chk("coll_rstn_a19", rstn_o, 3'b001);
        repeat (6) tick();
        chk("coll_rstn_a25", rstn_o, 3'b111);

        // LED modes from a fresh reset so the blink counter phase is known.
        rstn_soc   = 1'b0;
        led_mode_i = 8'b11_10_01_00;
        tick();
        rstn_soc = 1'b1;
        bad = 1'b0;
        for (int n = 1; n <= 130; n++) begin
            tick();
            c = (n - 1) % 64;
            exp_led = {(c < 8) ? 1'b1 : 1'b0, (c >= 32) ? 1'b1 : 1'b0, 1'b1, 1'b0};
            if (n == 1 || n == 8 || n == 9 || n == 32 || n == 33 || n == 65 || n == 97) begin
                chk($sformatf("led_e%0d", n), led_o, exp_led);
            end else if (led_o !== exp_led) begin
                bad = 1'b1;
            end
        end
        chk("led_all_cycles", bad, 1'b0);
        chk("led_run_rstn", rstn_o, 3'b111);

        // Asynchronous reset assertion between edges.
        #2;
        rstn_soc = 1'b0;
        #1;
        chk("async_led_o", led_o, 4'h0);
        chk("async_rstn_o", rstn_o, 3'b000);
        chk("async_busy", rst_busy_o, 1'b1);
        chk("async_btn_o", btn_o, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
